// File: rtl/i2c_stream_reader.sv
// I2C register-read master: writes a register pointer, re-starts, and
// streams the bytes read back out through a one-byte valid/ready buffer.
module i2c_stream_reader #(
    parameter int         CLK_DIV      = 16,
    parameter logic [6:0] DEF_DEV_ADDR = 7'h50
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [6:0] i_dev_addr,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_len,
    output logic       o_busy,
    output logic       o_err,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    input  logic       i_i2c_scl,
    input  logic       i_i2c_sda,
    output logic       o_i2c_scl,
    output logic       o_i2c_sda
);
    localparam int            DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, START, WBYTE, WACK, RSTART, RBYTE, MACK, STOP
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_div;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic [1:0]    r_idx;
    logic [7:0]    r_tx;
    logic [6:0]    r_rx;
    logic [6:0]    r_addr;
    logic [7:0]    r_reg;
    logic [7:0]    r_len;
    logic [8:0]    r_cnt;
    logic          r_lastb;
    logic          r_done;
    logic          r_busy;
    logic          r_err;
    logic          r_valid;
    logic [7:0]    r_data;
    logic          r_last;
    logic          r_scl;
    logic          r_sda;
    logic          r_scl_m, r_scl_s;
    logic          r_sda_m, r_sda_s;

    logic w_scl;
    logic w_sda;
    logic w_stall;
    logic w_wait;
    logic w_last;
    logic w_scl_t;
    logic w_sda_t;

    assign w_scl   = r_scl_s;
    assign w_sda   = r_sda_s;
    assign w_stall = (r_state == RBYTE) && (r_q == 2'd0) && r_valid;
    assign w_wait  = (r_q == 2'd2) && !w_scl;
    assign w_last  = (r_cnt == {1'b0, r_len});

    assign o_busy    = r_busy;
    assign o_err     = r_err;
    assign m_valid   = r_valid;
    assign m_data    = r_data;
    assign m_last    = r_last;
    assign o_i2c_scl = r_scl;
    assign o_i2c_sda = r_sda;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_scl_m <= 1'b1;
            r_scl_s <= 1'b1;
            r_sda_m <= 1'b1;
            r_sda_s <= 1'b1;
        end else begin
            r_scl_m <= i_i2c_scl;
            r_scl_s <= r_scl_m;
            r_sda_m <= i_i2c_sda;
            r_sda_s <= r_sda_m;
        end
    end

    // Quarter 0/1: SCL low, 2: released, 3: high. START/STOP move SDA in 2/3.
    always_comb begin
        w_scl_t = 1'b1;
        w_sda_t = 1'b1;
        unique case (r_state)
            START: w_sda_t = ~r_q[1];
            WBYTE: begin
                w_scl_t = r_q[1];
                w_sda_t = r_tx[7];
            end
            WACK, RBYTE: w_scl_t = r_q[1];
            RSTART: begin
                w_scl_t = r_q[1];
                w_sda_t = (r_q != 2'd3);
            end
            MACK: begin
                w_scl_t = r_q[1];
                w_sda_t = r_lastb;
            end
            STOP: begin
                w_scl_t = r_q[1] | r_done;
                w_sda_t = (r_q == 2'd3) | r_done;
            end
            default: begin
                w_scl_t = 1'b1;
                w_sda_t = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_q     <= 2'd0;
            r_bit   <= 3'd0;
            r_idx   <= 2'd0;
            r_tx    <= 8'd0;
            r_rx    <= 7'd0;
            r_addr  <= 7'd0;
            r_reg   <= 8'd0;
            r_len   <= 8'd0;
            r_cnt   <= 9'd0;
            r_lastb <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= 8'd0;
            r_last  <= 1'b0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
        end else begin
            r_scl <= w_scl_t;
            // SDA lags the SCL fall by one cycle so it never moves with SCL high
            if (!(r_q == 2'd0 && r_div == '0)) begin
                r_sda <= w_sda_t;
            end
            if (r_valid && m_ready) begin
                r_valid <= 1'b0;
            end
            if (r_state == IDLE) begin
                if (i_start) begin
                    r_busy  <= 1'b1;
                    r_err   <= 1'b0;
                    r_addr  <= (i_dev_addr == 7'd0) ? DEF_DEV_ADDR : i_dev_addr;
                    r_tx    <= {((i_dev_addr == 7'd0) ? DEF_DEV_ADDR : i_dev_addr), 1'b0};
                    r_reg   <= i_reg_addr;
                    r_len   <= i_len;
                    r_cnt   <= 9'd0;
                    r_idx   <= 2'd0;
                    r_bit   <= 3'd0;
                    r_q     <= 2'd0;
                    r_div   <= '0;
                    r_done  <= 1'b0;
                    r_lastb <= 1'b0;
                    r_state <= START;
                end
            end else if (r_done) begin
                if (!r_valid) begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            end else if (!w_stall && !w_wait) begin
                if (r_div != DIV_MAX) begin
                    r_div <= r_div + 1'b1;
                end else begin
                    r_div <= '0;
                    r_q   <= r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        unique case (r_state)
                            START: r_state <= WBYTE;
                            WBYTE: begin
                                r_tx  <= {r_tx[6:0], 1'b0};
                                r_bit <= r_bit + 3'd1;
                                if (r_bit == 3'd7) begin
                                    r_state <= WACK;
                                end
                            end
                            WACK: begin
                                if (w_sda) begin
                                    r_err   <= 1'b1;
                                    r_state <= STOP;
                                end else if (r_idx == 2'd0) begin
                                    r_tx    <= r_reg;
                                    r_idx   <= 2'd1;
                                    r_state <= WBYTE;
                                end else if (r_idx == 2'd1) begin
                                    r_idx   <= 2'd2;
                                    r_state <= RSTART;
                                end else begin
                                    r_state <= RBYTE;
                                end
                            end
                            RSTART: begin
                                r_tx    <= {r_addr, 1'b1};
                                r_state <= WBYTE;
                            end
                            RBYTE: begin
                                r_rx  <= {r_rx[5:0], w_sda};
                                r_bit <= r_bit + 3'd1;
                                if (r_bit == 3'd7) begin
                                    r_valid <= 1'b1;
                                    r_data  <= {r_rx, w_sda};
                                    r_last  <= w_last;
                                    r_lastb <= w_last;
                                    r_cnt   <= r_cnt + 9'd1;
                                    r_state <= MACK;
                                end
                            end
                            MACK: r_state <= r_lastb ? STOP : RBYTE;
                            STOP: r_done <= 1'b1;
                            default: r_state <= IDLE;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: doc/i2c_stream_reader.md
I2C_STREAM_READER -- requirements
Module: i2c_stream_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning system clocks per quarter I2C bit period (min 4).
REQ-002 SHALL have parameter [6:0] DEF_DEV_ADDR, default 7'h50, meaning the device address used when i_dev_addr is 0.
REQ-003 i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_start  in  1  one-cycle request to begin a read transaction; ignored while o_busy.
REQ-006 i_dev_addr  in  7  target device address, sampled at accepted i_start.
REQ-007 i_reg_addr  in  8  first register address, sampled at accepted i_start.
REQ-008 i_len  in  8  byte count minus one (0 = 1 byte, 255 = 256 bytes), sampled at accepted i_start.
REQ-009 o_busy  out  1  transaction in progress.
REQ-010 o_err  out  1  sticky NACK flag, cleared by the next accepted i_start.
REQ-011 m_valid, i_ready (wait: m_ready)  out/in  1 each  AXI-stream handshake toward wbi2cslave s_valid/s_ready.
REQ-012 m_data  out  8  received byte; m_last  out  1  final byte of transaction.
REQ-013 i_i2c_scl, i_i2c_sda  in  1 each  raw bus levels; o_i2c_scl, o_i2c_sda  out  1 each  open-drain drive (1 = release).

Function
REQ-014 i_i2c_scl/i_i2c_sda SHALL pass a 2-FF synchronizer before any use.
REQ-015 Transaction SHALL be: START, {addr,0}, ACK, i_reg_addr, ACK, repeated START, {addr,1}, ACK, (i_len+1) data bytes, STOP.
REQ-016 FSM states SHALL be IDLE, START, WBYTE, WACK, RSTART, RBYTE, MACK, STOP; WBYTE/WACK serve both address and register bytes via a byte index.
REQ-017 Each bit SHALL take 4 quarter phases of CLK_DIV clocks: SCL low/data change, SCL low/hold, SCL released, SCL high/sample.
REQ-018 Phase counter SHALL not advance in the "SCL released" phase until synchronized SCL reads 1 (clock stretching).
REQ-019 SDA SHALL change only while SCL is driven low, except START (SDA falls with SCL high) and STOP (SDA rises with SCL high).
REQ-020 Bytes SHALL be shifted MSB first; read bits are sampled in the SCL-high phase.
REQ-021 In WACK, sampled SDA=1 (NACK) SHALL set o_err and go to STOP; no stream output occurs.
REQ-022 In MACK, master SHALL drive SDA low (ACK) for all bytes except the last, which gets SDA released (NACK), then STOP.
REQ-023 A one-byte output buffer SHALL hold each received byte; m_valid rises the cycle after the 8th bit is sampled; m_last=1 iff byte count equals i_len.
REQ-024 m_valid/m_data/m_last SHALL remain stable until m_valid && m_ready.
REQ-025 If the buffer is still full when the next RBYTE would begin, the block SHALL hold SCL low (stall) until it empties.
REQ-026 o_busy SHALL be 1 from the cycle after an accepted i_start until STOP completes and the buffer has drained, then return to 0.
REQ-027 Byte counter SHALL be 9 bits so i_len=255 yields exactly 256 bytes with no wrap.
REQ-028 i_start while o_busy SHALL be ignored with no effect on o_err.

Reset
REQ-029 On i_reset: state=IDLE, o_i2c_scl=1, o_i2c_sda=1, o_busy=0, o_err=0, m_valid=0, m_last=0, m_data=0, counters=0.
REQ-030 Reset asserted mid-transaction SHALL release both lines immediately with no STOP generated; the partial stream is discarded.

Verification
REQ-031 i_dev_addr=7'h50, i_reg_addr=8'h10, i_len=3, slave model returns 11,22,33,44, m_ready=1 -> stream 11,22,33,44, m_last only on 44, o_err=0, bus bytes A0,10,A1.
REQ-032 Slave NACKs address 7'h23 -> o_err=1, STOP issued, m_valid never asserts, o_busy falls.
REQ-033 m_ready held low for 500 cycles after the first byte, i_len=1 -> SCL held low throughout, both bytes delivered in order, no lost data.
REQ-034 Slave stretches SCL for 100 cycles on bit 3 -> bit timing resumes correctly, data unchanged.
REQ-035 i_len=255 -> exactly 256 bytes, m_last on byte 256, final bit NACKed.
REQ-036 Reset pulse during RBYTE -> lines released within 1 cycle, outputs at reset values, next i_start runs a clean transaction.
